mem_stage: RTL and testbench

- Memory stage of the five-stage pipeline. Consumes the execute-to-memory bundle: ALU result, write select, write-data source, halt, next PC, data-memory read/write enables and store data.
- Holds the EX/MEM pipeline register and drives the data-memory request, stalling until the cache reports dhit.
- Produces the registered MEM/WB bundle for writeback.
- Owns halt retirement and a saturating memory-wait counter.

---
 rtl/mem_stage.sv | 258 +++++++++++++++++++++++++
 tb/tb_mem_stage.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory stage of the five-stage pipeline: EX/MEM register, data-memory request
// handshake, registered MEM/WB bundle, halt retirement and a memory-wait counter.
module mem_stage #(
    parameter int WORD_W = 32,
    parameter int REG_W  = 5,
    parameter int SRC_W  = 2,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ex_valid,
    input  logic [WORD_W-1:0] ex_alu_result,
    input  logic [REG_W-1:0]  ex_wsel,
    input  logic [SRC_W-1:0]  ex_wdat_source,
    input  logic              ex_halt,
    input  logic [WORD_W-1:0] ex_instr_npc,
    input  logic              ex_dmemREN,
    input  logic              ex_dmemWEN,
    input  logic [WORD_W-1:0] ex_dmemstore,
    input  logic              flush,
    output logic              mem_stall,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic              wb_valid,
    output logic [WORD_W-1:0] wb_alu_result,
    output logic [WORD_W-1:0] wb_dmemload,
    output logic [REG_W-1:0]  wb_wsel,
    output logic [SRC_W-1:0]  wb_wdat_source,
    output logic [WORD_W-1:0] wb_instr_npc,
    output logic              wb_halt,
    output logic [CNT_W-1:0]  mem_wait_cycles
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t state_q, state_d;

    // EX/MEM register fields; validity is carried by the state encoding
    logic [WORD_W-1:0] alu_q, alu_d;
    logic [REG_W-1:0]  wsel_q, wsel_d;
    logic [SRC_W-1:0]  src_q, src_d;
    logic              halt_q, halt_d;
    logic [WORD_W-1:0] npc_q, npc_d;
    logic              ren_q, ren_d;
    logic              wen_q, wen_d;
    logic [WORD_W-1:0] store_q, store_d;

    logic              wb_valid_q, wb_valid_d;
    logic [WORD_W-1:0] wb_alu_q, wb_alu_d;
    logic [WORD_W-1:0] wb_load_q, wb_load_d;
    logic [REG_W-1:0]  wb_wsel_q, wb_wsel_d;
    logic [SRC_W-1:0]  wb_src_q, wb_src_d;
    logic [WORD_W-1:0] wb_npc_q, wb_npc_d;
    logic              wb_halt_q, wb_halt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic held_valid_s;
    logic stall_s;
    logic ren_s;
    logic wen_s;
    logic halt_retire_s;
    logic capture_s;
    logic load_done_s;

    // State register
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM outputs: request strobes, stall and held-instruction validity
    always_comb begin
        held_valid_s = 1'b0;
        stall_s      = 1'b0;
        ren_s        = 1'b0;
        wen_s        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                held_valid_s = 1'b0;
            end
            ST_HOLD: begin
                held_valid_s = 1'b1;
            end
            ST_ACCESS: begin
                held_valid_s = 1'b1;
                ren_s        = ren_q;
                wen_s        = wen_q;
                stall_s      = ~dhit;
            end
            ST_HALTED: begin
                held_valid_s = 1'b0;
            end
            default: begin
                held_valid_s = 1'b0;
            end
        endcase
    end

    // Pipeline control: halt retirement wins over a capture in the same cycle
    always_comb begin
        halt_retire_s = 1'b0;
        capture_s     = 1'b0;
        load_done_s   = 1'b0;
        if (!stall_s) begin
            halt_retire_s = held_valid_s & halt_q;
            capture_s     = ex_valid & ~flush & (state_q != ST_HALTED) & ~(held_valid_s & halt_q);
            load_done_s   = (state_q == ST_ACCESS) & ren_q & dhit;
        end else begin
            halt_retire_s = 1'b0;
            capture_s     = 1'b0;
            load_done_s   = 1'b0;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                if (stall_s) begin
                    state_d = ST_ACCESS;
                end else if (halt_retire_s) begin
                    state_d = ST_HALTED;
                end else if (capture_s) begin
                    state_d = (ex_dmemREN | ex_dmemWEN) ? ST_ACCESS : ST_HOLD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // EX/MEM capture; a combined read+write request is treated as a store
    always_comb begin
        alu_d   = alu_q;
        wsel_d  = wsel_q;
        src_d   = src_q;
        halt_d  = halt_q;
        npc_d   = npc_q;
        ren_d   = ren_q;
        wen_d   = wen_q;
        store_d = store_q;
        if (capture_s) begin
            alu_d   = ex_alu_result;
            wsel_d  = ex_wsel;
            src_d   = ex_wdat_source;
            halt_d  = ex_halt;
            npc_d   = ex_instr_npc;
            ren_d   = ex_dmemREN & ~ex_dmemWEN;
            wen_d   = ex_dmemWEN;
            store_d = ex_dmemstore;
        end else begin
            halt_d  = halt_q;
        end
    end

    // MEM/WB update: a bubble while stalled, otherwise forward the held bundle
    always_comb begin
        wb_valid_d = 1'b0;
        wb_alu_d   = wb_alu_q;
        wb_load_d  = wb_load_q;
        wb_wsel_d  = wb_wsel_q;
        wb_src_d   = wb_src_q;
        wb_npc_d   = wb_npc_q;
        wb_halt_d  = wb_halt_q | halt_retire_s;
        if (!stall_s) begin
            wb_valid_d = held_valid_s;
            wb_alu_d   = alu_q;
            wb_load_d  = load_done_s ? dmemload : '0;
            wb_wsel_d  = wsel_q;
            wb_src_d   = src_q;
            wb_npc_d   = npc_q;
        end else begin
            wb_valid_d = 1'b0;
        end
    end

    // Saturating wait counter
    always_comb begin
        cnt_d = cnt_q;
        if (stall_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Datapath registers
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            alu_q      <= '0;
            wsel_q     <= '0;
            src_q      <= '0;
            halt_q     <= 1'b0;
            npc_q      <= '0;
            ren_q      <= 1'b0;
            wen_q      <= 1'b0;
            store_q    <= '0;
            wb_valid_q <= 1'b0;
            wb_alu_q   <= '0;
            wb_load_q  <= '0;
            wb_wsel_q  <= '0;
            wb_src_q   <= '0;
            wb_npc_q   <= '0;
            wb_halt_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            alu_q      <= alu_d;
            wsel_q     <= wsel_d;
            src_q      <= src_d;
            halt_q     <= halt_d;
            npc_q      <= npc_d;
            ren_q      <= ren_d;
            wen_q      <= wen_d;
            store_q    <= store_d;
            wb_valid_q <= wb_valid_d;
            wb_alu_q   <= wb_alu_d;
            wb_load_q  <= wb_load_d;
            wb_wsel_q  <= wb_wsel_d;
            wb_src_q   <= wb_src_d;
            wb_npc_q   <= wb_npc_d;
            wb_halt_q  <= wb_halt_d;
            cnt_q      <= cnt_d;
        end
    end

    assign mem_stall       = stall_s;
    assign dmemREN         = ren_s;
    assign dmemWEN         = wen_s;
    assign dmemaddr        = alu_q;
    assign dmemstore       = store_q;
    assign wb_valid        = wb_valid_q;
    assign wb_alu_result   = wb_alu_q;
    assign wb_dmemload     = wb_load_q;
    assign wb_wsel         = wb_wsel_q;
    assign wb_wdat_source  = wb_src_q;
    assign wb_instr_npc    = wb_npc_q;
    assign wb_halt         = wb_halt_q;
    assign mem_wait_cycles = cnt_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected MEM/WB bundles are queued when an
// instruction is driven and compared whenever wb_valid is observed.
module tb_mem_stage;

    logic        CLK;
    logic        nRST;
    logic        ex_valid;
    logic [31:0] ex_alu_result;
    logic [4:0]  ex_wsel;
    logic [1:0]  ex_wdat_source;
    logic        ex_halt;
    logic [31:0] ex_instr_npc;
    logic        ex_dmemREN;
    logic        ex_dmemWEN;
    logic [31:0] ex_dmemstore;
    logic        flush;
    logic        mem_stall;
    logic        dhit;
    logic [31:0] dmemload;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        wb_valid;
    logic [31:0] wb_alu_result;
    logic [31:0] wb_dmemload;
    logic [4:0]  wb_wsel;
    logic [1:0]  wb_wdat_source;
    logic [31:0] wb_instr_npc;
    logic        wb_halt;
    logic [15:0] mem_wait_cycles;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] load;
        logic [4:0]  wsel;
        logic [1:0]  src;
        logic [31:0] npc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   ren_cnt = 0;
    int   wen_cnt = 0;
    int   stall_cnt = 0;
    int   ren_base, wen_base, stall_base;

    mem_stage dut (
        .CLK(CLK), .nRST(nRST), .ex_valid(ex_valid), .ex_alu_result(ex_alu_result),
        .ex_wsel(ex_wsel), .ex_wdat_source(ex_wdat_source), .ex_halt(ex_halt),
        .ex_instr_npc(ex_instr_npc), .ex_dmemREN(ex_dmemREN), .ex_dmemWEN(ex_dmemWEN),
        .ex_dmemstore(ex_dmemstore), .flush(flush), .mem_stall(mem_stall), .dhit(dhit),
        .dmemload(dmemload), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
        .dmemstore(dmemstore), .wb_valid(wb_valid), .wb_alu_result(wb_alu_result),
        .wb_dmemload(wb_dmemload), .wb_wsel(wb_wsel), .wb_wdat_source(wb_wdat_source),
        .wb_instr_npc(wb_instr_npc), .wb_halt(wb_halt), .mem_wait_cycles(mem_wait_cycles)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [31:0] alu, input logic [4:0] wsel, input logic [1:0] src,
                         input logic halt, input logic [31:0] npc, input logic ren,
                         input logic wen, input logic [31:0] st);
        ex_valid       = 1'b1;
        ex_alu_result  = alu;
        ex_wsel        = wsel;
        ex_wdat_source = src;
        ex_halt        = halt;
        ex_instr_npc   = npc;
        ex_dmemREN     = ren;
        ex_dmemWEN     = wen;
        ex_dmemstore   = st;
    endtask

    task automatic idle_in();
        ex_valid   = 1'b0;
        ex_halt    = 1'b0;
        ex_dmemREN = 1'b0;
        ex_dmemWEN = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] alu, input logic [31:0] load, input logic [4:0] wsel,
                            input logic [1:0] src, input logic [31:0] npc);
        exp_t e;
        e.alu = alu; e.load = load; e.wsel = wsel; e.src = src; e.npc = npc;
        exp_q.push_back(e);
    endtask

    task automatic snap();
        ren_base   = ren_cnt;
        wen_base   = wen_cnt;
        stall_base = stall_cnt;
    endtask

    // Request/stall accounting and scoreboard comparison, once per cycle
    always @(negedge CLK) begin
        if (dmemREN === 1'b1) ren_cnt++;
        if (dmemWEN === 1'b1) wen_cnt++;
        if (mem_stall === 1'b1) stall_cnt++;
        if (nRST === 1'b1 && wb_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_val("wb_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_val("sb_alu", wb_alu_result, e.alu);
                check_val("sb_load", wb_dmemload, e.load);
                check_val("sb_wsel", 32'(wb_wsel), 32'(e.wsel));
                check_val("sb_src", 32'(wb_wdat_source), 32'(e.src));
                check_val("sb_npc", wb_instr_npc, e.npc);
            end
        end
    end

    initial begin
        nRST = 1'b0; flush = 1'b0; dhit = 1'b0; dmemload = 32'h0;
        ex_alu_result = 32'h0; ex_wsel = 5'd0; ex_wdat_source = 2'd0;
        ex_instr_npc = 32'h0; ex_dmemstore = 32'h0;
        idle_in();
        tick();
        tick();
        check_val("rst_wb_valid", 32'(wb_valid), 32'd0);
        check_val("rst_wb_halt", 32'(wb_halt), 32'd0);
        check_val("rst_wait", 32'(mem_wait_cycles), 32'd0);
        check_val("rst_ren", 32'(dmemREN), 32'd0);
        check_val("rst_wen", 32'(dmemWEN), 32'd0);
        check_val("rst_stall", 32'(mem_stall), 32'd0);
        nRST = 1'b1;

        // Back-to-back non-memory instructions
        snap();
        drive(32'h10, 5'd3, 2'd1, 1'b0, 32'h104, 1'b0, 1'b0, 32'h0);
        push_exp(32'h10, 32'h0, 5'd3, 2'd1, 32'h104);
        tick();
        check_val("nm_lat0_valid", 32'(wb_valid), 32'd0);
        check_val("nm_stall", 32'(mem_stall), 32'd0);
        drive(32'h20, 5'd4, 2'd0, 1'b0, 32'h108, 1'b0, 1'b0, 32'h0);
        push_exp(32'h20, 32'h0, 5'd4, 2'd0, 32'h108);
        tick();
        check_val("nm_lat1_valid", 32'(wb_valid), 32'd1);
        check_val("nm_alu", wb_alu_result, 32'h10);
        check_val("nm_wsel", 32'(wb_wsel), 32'd3);
        idle_in();
        tick();
        check_val("nm2_alu", wb_alu_result, 32'h20);
        tick();
        check_val("nm_drain_valid", 32'(wb_valid), 32'd0);
        check_val("nm_ren_cycles", 32'(ren_cnt - ren_base), 32'd0);
        check_val("nm_wen_cycles", 32'(wen_cnt - wen_base), 32'd0);

        // Load with three wait cycles
        snap();
        drive(32'h40, 5'd5, 2'd2, 1'b0, 32'h200, 1'b1, 1'b0, 32'h0);
        push_exp(32'h40, 32'hDEADBEEF, 5'd5, 2'd2, 32'h200);
        tick();
        idle_in();
        for (int i = 0; i < 3; i++) begin
            check_val("ld_ren", 32'(dmemREN), 32'd1);
            check_val("ld_addr", dmemaddr, 32'h40);
            check_val("ld_stall", 32'(mem_stall), 32'd1);
            check_val("ld_wb_bubble", 32'(wb_valid), 32'd0);
            tick();
        end
        dhit = 1'b1; dmemload = 32'hDEADBEEF;
        #1;
        check_val("ld_hit_stall", 32'(mem_stall), 32'd0);
        tick();
        dhit = 1'b0; dmemload = 32'h0;
        check_val("ld_wb_valid", 32'(wb_valid), 32'd1);
        check_val("ld_wb_load", wb_dmemload, 32'hDEADBEEF);
        check_val("ld_wait", 32'(mem_wait_cycles), 32'd3);
        check_val("ld_ren_after", 32'(dmemREN), 32'd0);
        check_val("ld_ren_cycles", 32'(ren_cnt - ren_base), 32'd4);
        check_val("ld_stall_cycles", 32'(stall_cnt - stall_base), 32'd3);

        // Store with REN and WEN both set, immediate hit
        snap();
        dhit = 1'b1;
        drive(32'h80, 5'd6, 2'd3, 1'b0, 32'h204, 1'b1, 1'b1, 32'h12345678);
        push_exp(32'h80, 32'h0, 5'd6, 2'd3, 32'h204);
        tick();
        idle_in();
        check_val("st_wen", 32'(dmemWEN), 32'd1);
        check_val("st_ren", 32'(dmemREN), 32'd0);
        check_val("st_data", dmemstore, 32'h12345678);
        check_val("st_addr", dmemaddr, 32'h80);
        check_val("st_stall", 32'(mem_stall), 32'd0);
        tick();
        dhit = 1'b0;
        check_val("st_wb_valid", 32'(wb_valid), 32'd1);
        check_val("st_wb_load", wb_dmemload, 32'h0);
        check_val("st_wen_cycles", 32'(wen_cnt - wen_base), 32'd1);
        check_val("st_ren_cycles", 32'(ren_cnt - ren_base), 32'd0);
        check_val("st_stall_cycles", 32'(stall_cnt - stall_base), 32'd0);

        // Halt followed by further valid instructions
        snap();
        drive(32'h99, 5'd0, 2'd0, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0);
        push_exp(32'h99, 32'h0, 5'd0, 2'd0, 32'h300);
        tick();
        check_val("h_pre_halt", 32'(wb_halt), 32'd0);
        drive(32'h1, 5'd1, 2'd0, 1'b0, 32'h304, 1'b1, 1'b0, 32'h0);
        tick();
        check_val("h_halt", 32'(wb_halt), 32'd1);
        check_val("h_valid", 32'(wb_valid), 32'd1);
        drive(32'h2, 5'd2, 2'd0, 1'b0, 32'h308, 1'b0, 1'b1, 32'h55);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("h_sticky", 32'(wb_halt), 32'd1);
            check_val("h_no_valid", 32'(wb_valid), 32'd0);
            check_val("h_no_stall", 32'(mem_stall), 32'd0);
        end
        idle_in();
        check_val("h_ren_cycles", 32'(ren_cnt - ren_base), 32'd0);
        check_val("h_wen_cycles", 32'(wen_cnt - wen_base), 32'd0);

        // Reset leaves HALTED, then reset again in the middle of an access
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        check_val("r_halt_clear", 32'(wb_halt), 32'd0);
        drive(32'h50, 5'd8, 2'd2, 1'b0, 32'h400, 1'b1, 1'b0, 32'h0);
        tick();
        idle_in();
        tick();
        tick();
        check_val("r_mid_stall", 32'(mem_stall), 32'd1);
        check_val("r_mid_wait", 32'(mem_wait_cycles), 32'd2);
        nRST = 1'b0;
        tick();
        check_val("r_ren", 32'(dmemREN), 32'd0);
        check_val("r_stall", 32'(mem_stall), 32'd0);
        check_val("r_wb_valid", 32'(wb_valid), 32'd0);
        check_val("r_wait", 32'(mem_wait_cycles), 32'd0);
        nRST = 1'b1;
        tick();

        // Long stall saturates the wait counter
        drive(32'h60, 5'd7, 2'd2, 1'b0, 32'h500, 1'b1, 1'b0, 32'h0);
        push_exp(32'h60, 32'hCAFEF00D, 5'd7, 2'd2, 32'h500);
        tick();
        idle_in();
        repeat (70000) tick();
        check_val("sat_wait", 32'(mem_wait_cycles), 32'h0000FFFF);
        check_val("sat_stall", 32'(mem_stall), 32'd1);
        dhit = 1'b1; dmemload = 32'hCAFEF00D;
        tick();
        dhit = 1'b0; dmemload = 32'h0;
        check_val("sat_wb_load", wb_dmemload, 32'hCAFEF00D);
        check_val("sat_no_wrap", 32'(mem_wait_cycles), 32'h0000FFFF);

        // Flushed instruction is never captured
        snap();
        flush = 1'b1;
        drive(32'h70, 5'd9, 2'd1, 1'b0, 32'h600, 1'b1, 1'b0, 32'h0);
        tick();
        flush = 1'b0;
        idle_in();
        check_val("fl_stall", 32'(mem_stall), 32'd0);
        check_val("fl_ren", 32'(dmemREN), 32'd0);
        tick();
        check_val("fl_wb_valid", 32'(wb_valid), 32'd0);
        check_val("fl_ren_cycles", 32'(ren_cnt - ren_base), 32'd0);

        tick();
        tick();
        check_val("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
